// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Purpose  : Shared UART definitions: frame state encoding and default
//            timing constants, common to the TX and RX controllers.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  // Default number of baud ticks per bit period.
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  // Default number of data bits per frame.
  localparam int UART_DATA_BITS_DEFAULT  = 8;

  // Frame state encoding, shared so TX and RX decode states identically.
  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = UART_ST_IDLE,
    ST_START  = UART_ST_START,
    ST_DATA   = UART_ST_DATA,
    ST_PARITY = UART_ST_PARITY,
    ST_STOP   = UART_ST_STOP
  } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_ctrl_if
// Purpose  : Byte handshake between a TX byte source (FIFO / register port)
//            and the UART transmit controller.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEFAULT
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Byte source side.
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmit controller side.
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_ctrl
// Purpose  : UART transmit controller. Serialises a parallel byte into a
//            start / data (LSB first) / optional parity / stop frame, with
//            bit timing taken from an external oversampling tick.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
  parameter int SB_TICKS   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  wire            clk,
  input  wire            reset_n,
  input  wire            s_tick,
  uart_tx_ctrl_if.slave  bus_if,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done_tick
);

  // The tick counter must reach the longer of the bit and stop periods.
  localparam int TICK_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
  localparam int TW       = $clog2(TICK_MAX);
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);
  localparam logic          PAR_EN   = (PARITY_EN != 0);

  uart_state_e            state_q, state_d;
  logic [TW-1:0]          tick_q,  tick_d;
  logic [BW-1:0]          bit_q,   bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q,   par_d;
  logic                   tx_q,    tx_d;
  logic                   done_q,  done_d;

  // Frame state and datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state sequencing: advance only on s_tick once a period's last tick lands.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ready is high throughout IDLE, so valid alone completes the handshake.
        // Any s_tick on this edge is deliberately not counted.
        if (bus_if.tx_valid) begin
          shift_d = bus_if.tx_data;
          par_d   = (^bus_if.tx_data) ^ PAR_ODD;
          tick_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              if (PAR_EN) state_d = ST_PARITY;
              else        state_d = ST_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
      end
    endcase

    // Line level is decided from the upcoming state so tx changes on the
    // same edge as the state register, with no extra clock of lag.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign bus_if.tx_ready = (state_q == ST_IDLE);
  assign tx              = tx_q;
  assign tx_busy         = (state_q != ST_IDLE);
  assign tx_done_tick    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_ctrl
// Purpose  : Directed self-checking bench for uart_tx_ctrl. Four instances
//            cover 8N1, 8E1, 8O1 and 8N with a 32-tick stop period.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_ctrl;

  logic       clk;
  logic       reset_n = 1'b0;
  logic       s_tick  = 1'b0;
  logic       tick_en = 1'b0;
  int         tcnt    = 0;

  logic [7:0] data_a [4];
  logic [3:0] valid_v;
  wire  [3:0] tx_v, busy_v, done_v, rdy_v;

  int checks   = 0;
  int failures = 0;
  int done_cnt [4] = '{default: 0};

  uart_tx_ctrl_if #(.DATA_BITS(8)) if0 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if1 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if2 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_data = data_a[0];  assign if0.tx_valid = valid_v[0];  assign rdy_v[0] = if0.tx_ready;
  assign if1.tx_data = data_a[1];  assign if1.tx_valid = valid_v[1];  assign rdy_v[1] = if1.tx_ready;
  assign if2.tx_data = data_a[2];  assign if2.tx_valid = valid_v[2];  assign rdy_v[2] = if2.tx_ready;
  assign if3.tx_data = data_a[3];  assign if3.tx_valid = valid_v[3];  assign rdy_v[3] = if3.tx_ready;

  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus_if(if0),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));
  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus_if(if1),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));
  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus_if(if2),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));
  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .SB_TICKS(32), .PARITY_EN(0), .PARITY_ODD(0)) u_8n2 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus_if(if3),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done_tick(done_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one-clock pulse every 4 clocks, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tcnt   = (tcnt + 1) % 4;
      s_tick = tick_en && (tcnt == 0);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
  end

  // Wait for n s_tick edges after the current time, then settle 1 time unit.
  task automatic tick_wait(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (s_tick) c++;
    end
    #1;
  endtask

  // Present a byte and wait for the handshake edge; returns 1 unit after it.
  task automatic send(input int s, input logic [7:0] d, input bit hold);
    int guard;
    guard      = 0;
    data_a[s]  = d;
    valid_v[s] = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_v[s]) break;
      guard++;
      if (guard > 2000) begin
        checks++; failures++;
        $display("FAIL send_timeout dut=%0d: ready=%b, want 1", s, rdy_v[s]);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) valid_v[s] = 1'b0;
  endtask

  // Sample n bit periods mid-bit starting from an acceptance edge.
  // Consumes 8 + 16*(n-1) ticks.
  task automatic capture(input int s, input int n, output logic [15:0] bits);
    bits = '0;
    tick_wait(8);
    bits[0] = tx_v[s];
    for (int k = 1; k < n; k++) begin
      tick_wait(16);
      bits[k] = tx_v[s];
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({tx_v[s], rdy_v[s], busy_v[s], done_v[s]} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_state dut=%0d: {tx,rdy,busy,done}=%b, want 1100", s,
                 {tx_v[s], rdy_v[s], busy_v[s], done_v[s]});
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({tx_v[0], rdy_v[0], busy_v[0]} !== 3'b110) begin
      failures++;
      $display("FAIL idle_after_reset: {tx,rdy,busy}=%b, want 110", {tx_v[0], rdy_v[0], busy_v[0]});
    end
  endtask

  task automatic test_8n1();
    logic [15:0] b;
    int d0;
    d0 = done_cnt[0];
    send(0, 8'h55, 1'b0);
    checks++;
    if ({tx_v[0], busy_v[0], rdy_v[0]} !== 3'b010) begin
      failures++;
      $display("FAIL 8n1_accept: {tx,busy,rdy}=%b, want 010", {tx_v[0], busy_v[0], rdy_v[0]});
    end
    capture(0, 10, b);
    checks++;
    if (b !== 16'h02AA) begin failures++; $display("FAIL 8n1_bits_55: got %h, want 02aa", b); end
    tick_wait(7);
    checks++;
    if ({done_v[0], busy_v[0], tx_v[0]} !== 3'b011) begin
      failures++;
      $display("FAIL 8n1_tick159: {done,busy,tx}=%b, want 011", {done_v[0], busy_v[0], tx_v[0]});
    end
    tick_wait(1);
    checks++;
    if ({done_v[0], rdy_v[0], busy_v[0]} !== 3'b110) begin
      failures++;
      $display("FAIL 8n1_tick160: {done,rdy,busy}=%b, want 110", {done_v[0], rdy_v[0], busy_v[0]});
    end
    tick_wait(20);
    checks++;
    if (done_cnt[0] - d0 !== 1) begin
      failures++;
      $display("FAIL 8n1_done_count: got %0d, want 1", done_cnt[0] - d0);
    end
  endtask

  task automatic test_parity();
    logic [15:0] b;
    send(1, 8'h07, 1'b0);
    capture(1, 11, b);
    checks++;
    if (b !== 16'h060E) begin failures++; $display("FAIL even_parity_07: got %h, want 060e", b); end
    tick_wait(7);
    checks++;
    if ({done_v[1], busy_v[1]} !== 2'b01) begin
      failures++;
      $display("FAIL even_tick175: {done,busy}=%b, want 01", {done_v[1], busy_v[1]});
    end
    tick_wait(1);
    checks++;
    if ({done_v[1], rdy_v[1]} !== 2'b11) begin
      failures++;
      $display("FAIL even_tick176: {done,rdy}=%b, want 11", {done_v[1], rdy_v[1]});
    end

    send(2, 8'h07, 1'b0);
    capture(2, 11, b);
    checks++;
    if (b !== 16'h040E) begin failures++; $display("FAIL odd_parity_07: got %h, want 040e", b); end
    tick_wait(8);
    checks++;
    if ({done_v[2], rdy_v[2]} !== 2'b11) begin
      failures++;
      $display("FAIL odd_tick176: {done,rdy}=%b, want 11", {done_v[2], rdy_v[2]});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b;
    send(0, 8'hA5, 1'b1);
    data_a[0] = 8'h3C;
    capture(0, 10, b);
    checks++;
    if (b !== 16'h034A) begin failures++; $display("FAIL b2b_first_A5: got %h, want 034a", b); end
    tick_wait(8);
    checks++;
    if ({done_v[0], rdy_v[0], valid_v[0]} !== 3'b111) begin
      failures++;
      $display("FAIL b2b_handshake_on_done: {done,rdy,valid}=%b, want 111",
               {done_v[0], rdy_v[0], valid_v[0]});
    end
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    checks++;
    if ({busy_v[0], tx_v[0]} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_second_start: {busy,tx}=%b, want 10", {busy_v[0], tx_v[0]});
    end
    capture(0, 10, b);
    checks++;
    if (b !== 16'h0278) begin failures++; $display("FAIL b2b_second_3C: got %h, want 0278", b); end
    tick_wait(8);
    checks++;
    if (done_v[0] !== 1'b1) begin failures++; $display("FAIL b2b_second_done: got %b, want 1", done_v[0]); end
  endtask

  task automatic test_valid_while_busy();
    logic [15:0] b;
    send(0, 8'h81, 1'b0);
    fork
      capture(0, 10, b);
      begin
        tick_wait(40);
        data_a[0]  = 8'hFF;
        valid_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy_v[0], busy_v[0]} !== 2'b01) begin
          failures++;
          $display("FAIL busy_ignores_valid: {rdy,busy}=%b, want 01", {rdy_v[0], busy_v[0]});
        end
      end
    join
    checks++;
    if (b !== 16'h0302) begin failures++; $display("FAIL busy_frame_81: got %h, want 0302", b); end
    tick_wait(7);
    checks++;
    if ({done_v[0], busy_v[0]} !== 2'b01) begin
      failures++;
      $display("FAIL busy_not_accepted_early: {done,busy}=%b, want 01", {done_v[0], busy_v[0]});
    end
    tick_wait(1);
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    checks++;
    if ({busy_v[0], tx_v[0]} !== 2'b10) begin
      failures++;
      $display("FAIL ff_accepted_after_done: {busy,tx}=%b, want 10", {busy_v[0], tx_v[0]});
    end
    capture(0, 10, b);
    checks++;
    if (b !== 16'h03FE) begin failures++; $display("FAIL frame_FF: got %h, want 03fe", b); end
    tick_wait(8);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] b;
    int d0;
    send(0, 8'h55, 1'b0);
    tick_wait(72);
    checks++;
    if (tx_v[0] !== 1'b0) begin failures++; $display("FAIL mid_data_bit3: tx=%b, want 0", tx_v[0]); end
    d0 = done_cnt[0];
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_v[0], rdy_v[0], busy_v[0]} !== 3'b110) begin
      failures++;
      $display("FAIL async_reset_mid_frame: {tx,rdy,busy}=%b, want 110",
               {tx_v[0], rdy_v[0], busy_v[0]});
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt[0] !== d0) begin
      failures++;
      $display("FAIL reset_no_done: done pulses=%0d, want 0", done_cnt[0] - d0);
    end
    send(0, 8'h81, 1'b0);
    capture(0, 10, b);
    checks++;
    if (b !== 16'h0302) begin failures++; $display("FAIL after_reset_81: got %h, want 0302", b); end
    tick_wait(8);
    checks++;
    if (done_v[0] !== 1'b1) begin failures++; $display("FAIL after_reset_done: got %b, want 1", done_v[0]); end
  endtask

  task automatic test_stop_hold();
    logic [15:0] b;
    int d0;
    send(3, 8'hC3, 1'b0);
    capture(3, 10, b);
    checks++;
    if (b !== 16'h0386) begin failures++; $display("FAIL sb32_bits_C3: got %h, want 0386", b); end
    d0 = done_cnt[3];
    tick_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (25) @(posedge clk);
      #1;
      checks++;
      if ({tx_v[3], busy_v[3], done_v[3]} !== 3'b110) begin
        failures++;
        $display("FAIL sb32_hold_%0d: {tx,busy,done}=%b, want 110", k,
                 {tx_v[3], busy_v[3], done_v[3]});
      end
    end
    tick_en = 1'b1;
    tick_wait(23);
    checks++;
    if ({done_v[3], busy_v[3], done_cnt[3] - d0} !== {2'b01, 32'sd0}) begin
      failures++;
      $display("FAIL sb32_tick31: done=%b busy=%b pulses=%0d, want 0 1 0",
               done_v[3], busy_v[3], done_cnt[3] - d0);
    end
    tick_wait(1);
    checks++;
    if ({done_v[3], rdy_v[3]} !== 2'b11) begin
      failures++;
      $display("FAIL sb32_tick32: {done,rdy}=%b, want 11", {done_v[3], rdy_v[3]});
    end
  endtask

  initial begin
    valid_v = '0;
    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
    tick_en = 1'b1;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_frame();
    test_stop_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
